// File: rtl/mau_scheduler_if.sv
// mau_scheduler_if: bundles the requester-side and MAU-side pins of one MAU scheduler.
// Latency: none; this is wiring only.
// Backpressure: none here. Requesters hold req until done, and the scheduler waits on mau_busy.
//
// Ports/signals:
//   requester -> scheduler: req, req_mode, req_add_mode, req_base (2*ADDR_W), req_passes (4)
//   scheduler -> requester: gnt, done, result_valid, err
//   MAU       -> scheduler: mau_busy
//   scheduler -> MAU      : mau_start, mau_mode, mau_add_mode, mau_read_output, matram_addr
// Modports: slave = scheduler view, master = front end / MAU view.
interface mau_scheduler_if #(
    parameter int ADDR_W = 4
);
    logic [1:0]          req;
    logic [1:0]          req_mode;
    logic [1:0]          req_add_mode;
    logic [2*ADDR_W-1:0] req_base;
    logic [3:0]          req_passes;
    logic [1:0]          gnt;
    logic [1:0]          done;
    logic                result_valid;
    logic                err;
    logic                mau_busy;
    logic                mau_start;
    logic                mau_mode;
    logic                mau_add_mode;
    logic                mau_read_output;
    logic [ADDR_W-1:0]   matram_addr;

    modport slave (
        input  req, req_mode, req_add_mode, req_base, req_passes, mau_busy,
        output gnt, done, result_valid, err,
               mau_start, mau_mode, mau_add_mode, mau_read_output, matram_addr
    );

    modport master (
        output req, req_mode, req_add_mode, req_base, req_passes, mau_busy,
        input  gnt, done, result_valid, err,
               mau_start, mau_mode, mau_add_mode, mau_read_output, matram_addr
    );
endinterface

// File: rtl/mau_scheduler.sv
// mau_scheduler: runs multi-pass MAU jobs for two requesters, with round-robin arbitration on ties.
// Latency: gnt one edge after req is seen in IDLE. Each pass costs 3 cycles plus MAU busy time. done pulses one cycle after the final READ.
// Backpressure: requesters hold req until done. The scheduler waits on mau_busy, bounded by TIMEOUT only with MAU_SCHED_WATCHDOG_EN.
//
// Ports: clk, reset (asynchronous, active-high), bus (mau_scheduler_if.slave):
//   requester side: req/req_mode/req_add_mode/req_base/req_passes in; gnt/done/result_valid/err out
//   MAU side:       mau_busy in; mau_start/mau_mode/mau_add_mode/mau_read_output/matram_addr out
// Optional feature macro: MAU_SCHED_WATCHDOG_EN (busy watchdog). When it is not defined, err is constant 0.
module mau_scheduler #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 31
) (
    input  logic               clk,
    input  logic               reset,
    mau_scheduler_if.slave     bus
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mau_scheduler: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_READ,
        S_DONE
    } state_t;

    state_t            state_q;
    logic              last_q;       // index of the most recently granted requester
    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic              start_q;
    logic              rd_q;
    logic              rv_q;
    logic              mode_q;
    logic              add_q;
    logic [1:0]        passes_q;
    logic [1:0]        pass_q;
    logic [ADDR_W-1:0] addr_q;

    // Arbitration and field selection for the requester that would win in IDLE.
    logic              sel_d;
    logic [ADDR_W-1:0] sel_base_d;
    logic [1:0]        sel_passes_d;

    always_comb begin
        sel_d = bus.req[1];
        if (bus.req == 2'b11) begin
            sel_d = ~last_q;
        end
        sel_base_d   = sel_d ? bus.req_base[ADDR_W +: ADDR_W] : bus.req_base[0 +: ADDR_W];
        sel_passes_d = sel_d ? bus.req_passes[3:2] : bus.req_passes[1:0];
    end

`ifdef MAU_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic            err_q;
    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_inc_d;
    logic            wd_hit_d;

    // The count reaches TIMEOUT on the cycle that would make it TIMEOUT.
    always_comb begin
        wd_inc_d = wd_q + WD_W'(1);
        wd_hit_d = (wd_inc_d == WD_W'(TIMEOUT));
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            gnt_q    <= '0;
            done_q   <= '0;
            start_q  <= 1'b0;
            rd_q     <= 1'b0;
            rv_q     <= 1'b0;
            mode_q   <= 1'b0;
            add_q    <= 1'b0;
            passes_q <= '0;
            pass_q   <= '0;
            addr_q   <= '0;
`ifdef MAU_SCHED_WATCHDOG_EN
            err_q    <= 1'b0;
            wd_q     <= '0;
`endif
        end else begin
            // Every strobe is a single-cycle pulse unless a transition below re-asserts it.
            start_q <= 1'b0;
            rd_q    <= 1'b0;
            rv_q    <= 1'b0;
            done_q  <= '0;
`ifdef MAU_SCHED_WATCHDOG_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (|bus.req) begin
                        gnt_q    <= sel_d ? 2'b10 : 2'b01;
                        last_q   <= sel_d;
                        mode_q   <= bus.req_mode[sel_d];
                        add_q    <= bus.req_add_mode[sel_d];
                        passes_q <= sel_passes_d;
                        pass_q   <= '0;
                        addr_q   <= sel_base_d;
                        start_q  <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT_START;
`ifdef MAU_SCHED_WATCHDOG_EN
                    wd_q    <= '0;
`endif
                end
                S_WAIT_START: begin
                    if (bus.mau_busy) begin
                        state_q <= S_WAIT_DONE;
`ifdef MAU_SCHED_WATCHDOG_EN
                        wd_q    <= '0;
                    end else if (wd_hit_d) begin
                        // The MAU never started. Abandon the job, but still hand done back.
                        err_q   <= 1'b1;
                        done_q  <= gnt_q;
                        gnt_q   <= '0;
                        mode_q  <= 1'b0;
                        add_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        wd_q    <= wd_inc_d;
`endif
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.mau_busy) begin
                        rd_q    <= 1'b1;
                        rv_q    <= 1'b1;
                        state_q <= S_READ;
`ifdef MAU_SCHED_WATCHDOG_EN
                    end else if (wd_hit_d) begin
                        // The MAU is stuck busy. Skip READ so no stale data is flagged valid.
                        err_q   <= 1'b1;
                        done_q  <= gnt_q;
                        gnt_q   <= '0;
                        mode_q  <= 1'b0;
                        add_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        wd_q    <= wd_inc_d;
`endif
                    end
                end
                S_READ: begin
                    if (pass_q == passes_q) begin
                        done_q  <= gnt_q;
                        gnt_q   <= '0;
                        mode_q  <= 1'b0;
                        add_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        // Passes use consecutive rows, so stepping the held address wraps naturally.
                        pass_q  <= pass_q + 2'd1;
                        addr_q  <= addr_q + ADDR_W'(1);
                        start_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.done            = done_q;
    assign bus.result_valid    = rv_q;
    assign bus.mau_start       = start_q;
    assign bus.mau_mode        = mode_q;
    assign bus.mau_add_mode    = add_q;
    assign bus.mau_read_output = rd_q;
    assign bus.matram_addr     = addr_q;
`ifdef MAU_SCHED_WATCHDOG_EN
    assign bus.err             = err_q;
`else
    assign bus.err             = 1'b0;
`endif

endmodule
